// File: rtl/config_ctrl_pkg.sv
// Shared types, constants and field-width helpers for the leaf configuration controller.
package config_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_OK      = 4'h1,
      ST_CLR     = 4'h2,
      ST_BADPORT = 4'h3,
      ST_RDBK    = 4'h4
   } ack_status_e;

   typedef enum logic {
      ACK_IDLE = 1'b0,
      ACK_PEND = 1'b1
   } ack_state_e;

   // Packet port-field values that address the controller itself
   localparam int PORT_CFG_OUT = 0;
   localparam int PORT_CFG_IN  = 1;
   localparam int PORT_RDBK    = 2;

   localparam int RST_SRC_PORT = 9;
   localparam int RST_DST_PORT = 2;

   function automatic int in_field_w(input int leaf_bits, input int port_bits);
      return leaf_bits + port_bits;
   endfunction

   function automatic int out_field_w(input int leaf_bits, input int port_bits, input int addr_bits);
      return leaf_bits + port_bits + 2 * addr_bits + 3;
   endfunction

   function automatic int out_field_base(input int in_w, input int num_in);
      return in_w * num_in;
   endfunction

endpackage

// File: rtl/config_controls_gen_if.sv
// Configuration packet input and acknowledgement output bus of the leaf controller.
interface config_controls_gen_if #(
   parameter int PACKET_BITS = 97
);
   logic [PACKET_BITS-1:0] configure_in;
   logic                   configure_ready;
   logic [PACKET_BITS-1:0] ack_out;
   logic                   ack_valid;
   logic                   ack_ready;

   modport master (
      output configure_in, ack_ready,
      input  configure_ready, ack_out, ack_valid
   );

   modport slave (
      input  configure_in, ack_ready,
      output configure_ready, ack_out, ack_valid
   );
endinterface

// File: rtl/config_ack_slot.sv
// Single-entry valid/ready holding register for outgoing acknowledgement packets.
module config_ack_slot
   import config_ctrl_pkg::*;
#(
   parameter int PACKET_BITS = 97
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   load,
   input  logic [PACKET_BITS-1:0] load_data,
   input  logic                   ack_ready,
   output logic                   ack_valid,
   output logic [PACKET_BITS-1:0] ack_out
);

   ack_state_e             state_reg, state_next;
   logic [PACKET_BITS-1:0] data_reg, data_next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ACK_IDLE;
         data_reg  <= '0;
      end else begin
         state_reg <= state_next;
         data_reg  <= data_next;
      end
   end

   // load is only possible while the slot is empty or draining this cycle
   always_comb begin
      state_next = state_reg;
      data_next  = data_reg;
      case (state_reg)
         ACK_IDLE: begin
            if (load) begin
               state_next = ACK_PEND;
               data_next  = load_data;
            end
         end
         ACK_PEND: begin
            if (load) begin
               data_next = load_data;
            end else if (ack_ready) begin
               state_next = ACK_IDLE;
            end
         end
         default: state_next = ACK_IDLE;
      endcase
   end

   assign ack_valid = (state_reg == ACK_PEND);
   assign ack_out   = data_reg;

endmodule

// File: rtl/config_controls_gen.sv
// Leaf configuration controller: decodes config packets into per-port control fields and acks.
// Define CFG_READBACK_EN to answer port-2 packets with the current register contents.
module config_controls_gen
   import config_ctrl_pkg::*;
#(
   parameter int PACKET_BITS   = 97,
   parameter int NUM_LEAF_BITS = 6,
   parameter int NUM_PORT_BITS = 4,
   parameter int NUM_ADDR_BITS = 7,
   parameter int PAYLOAD_BITS  = 64,
   parameter int NUM_IN_PORTS  = 7,
   parameter int NUM_OUT_PORTS = 7,
   parameter int IN_PORT_BASE  = 2,
   parameter int OUT_PORT_BASE = 9,
   parameter int ACK_LEAF      = 0,
   parameter int ACK_PORT      = 1,
   localparam int IN_W     = in_field_w(NUM_LEAF_BITS, NUM_PORT_BITS),
   localparam int OUT_W    = out_field_w(NUM_LEAF_BITS, NUM_PORT_BITS, NUM_ADDR_BITS),
   localparam int OUT_BASE = out_field_base(IN_W, NUM_IN_PORTS),
   localparam int CTRL_W   = OUT_BASE + OUT_W * NUM_OUT_PORTS
) (
   input  logic                     clk,
   input  logic                     reset_n,
   config_controls_gen_if.slave     cfg,
   output logic [CTRL_W-1:0]        control_reg,
   output logic [NUM_IN_PORTS-1:0]  in_configured,
   output logic [NUM_OUT_PORTS-1:0] out_configured,
   output logic                     all_configured
);

   localparam int RB_W     = NUM_LEAF_BITS + NUM_PORT_BITS + 2 * NUM_ADDR_BITS;
   localparam int FLD_W    = NUM_PORT_BITS + RB_W;
   localparam int PORT_MSB = PACKET_BITS - 2 - NUM_LEAF_BITS;

   logic                     pkt_vld, accept, is_cfg_out, is_cfg_in, soft_clr;
   logic [NUM_PORT_BITS-1:0] pkt_port, self_port, fld_port;
   logic [NUM_LEAF_BITS-1:0] fld_leaf;
   logic [NUM_ADDR_BITS-1:0] fld_addr, fld_free;
   logic [PAYLOAD_BITS-1:0]  payload;
   logic [31:0]              self_idx, port_idx;
   logic                     unused_pkt;

   logic [NUM_IN_PORTS-1:0]  in_match, in_sel, in_cfg_reg;
   logic [NUM_OUT_PORTS-1:0] out_match, out_sel, add_match, add_sel;
   logic [NUM_OUT_PORTS-1:0] out_cfg_reg, upd_en_reg, add_free_reg;

   logic [NUM_LEAF_BITS-1:0] src_leaf_reg  [NUM_IN_PORTS];
   logic [NUM_PORT_BITS-1:0] src_port_reg  [NUM_IN_PORTS];
   logic [NUM_LEAF_BITS-1:0] dst_leaf_reg  [NUM_OUT_PORTS];
   logic [NUM_PORT_BITS-1:0] dst_port_reg  [NUM_OUT_PORTS];
   logic [NUM_ADDR_BITS-1:0] bram_addr_reg [NUM_OUT_PORTS];
   logic [NUM_ADDR_BITS-1:0] freespace_reg [NUM_OUT_PORTS];

   ack_status_e              ack_status;
   logic                     ack_gen;
   logic [RB_W-1:0]          rb_fields;
   logic [PACKET_BITS-1:0]   ack_pkt;

   assign unused_pkt = ^cfg.configure_in;
   assign pkt_vld    = cfg.configure_in[PACKET_BITS-1];
   assign pkt_port   = cfg.configure_in[PORT_MSB -: NUM_PORT_BITS];
   assign payload    = cfg.configure_in[PAYLOAD_BITS-1:0];
   assign {self_port, fld_leaf, fld_port, fld_addr, fld_free} = payload[PAYLOAD_BITS-1 -: FLD_W];
   assign self_idx   = 32'(self_port);
   assign port_idx   = 32'(pkt_port);

   assign cfg.configure_ready = !cfg.ack_valid || cfg.ack_ready;
   assign accept     = pkt_vld && cfg.configure_ready;
   assign is_cfg_out = accept && (port_idx == PORT_CFG_OUT);
   assign is_cfg_in  = accept && (port_idx == PORT_CFG_IN);
   assign soft_clr   = is_cfg_out && (self_idx == 0);

   for (genvar gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in
      assign in_match[gi] = (self_idx == 32'(IN_PORT_BASE + gi));
      assign in_sel[gi]   = is_cfg_in && in_match[gi];
      assign control_reg[IN_W*gi +: IN_W] = {src_leaf_reg[gi], src_port_reg[gi]};
   end

   for (genvar gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_out
      assign out_match[gi] = (self_idx == 32'(OUT_PORT_BASE + gi));
      assign out_sel[gi]   = is_cfg_out && out_match[gi];
      // Credit returns are addressed by packet port rather than by payload self_port
      assign add_match[gi] = (port_idx == 32'(OUT_PORT_BASE + gi));
      assign add_sel[gi]   = accept && add_match[gi];
      assign control_reg[OUT_BASE + OUT_W*gi +: OUT_W] =
         {upd_en_reg[gi], upd_en_reg[gi], add_free_reg[gi], dst_leaf_reg[gi],
          dst_port_reg[gi], bram_addr_reg[gi], freespace_reg[gi]};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NUM_IN_PORTS; k++) begin
            src_leaf_reg[k] <= '0;
            src_port_reg[k] <= NUM_PORT_BITS'(RST_SRC_PORT);
         end
         in_cfg_reg <= '0;
      end else if (soft_clr) begin
         for (int k = 0; k < NUM_IN_PORTS; k++) begin
            src_leaf_reg[k] <= '0;
            src_port_reg[k] <= NUM_PORT_BITS'(RST_SRC_PORT);
         end
         in_cfg_reg <= '0;
      end else begin
         for (int k = 0; k < NUM_IN_PORTS; k++) begin
            if (in_sel[k]) begin
               src_leaf_reg[k] <= fld_leaf;
               src_port_reg[k] <= fld_port;
            end
         end
         in_cfg_reg <= in_cfg_reg | in_sel;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NUM_OUT_PORTS; k++) begin
            dst_leaf_reg[k]  <= '0;
            dst_port_reg[k]  <= NUM_PORT_BITS'(RST_DST_PORT);
            bram_addr_reg[k] <= '0;
            freespace_reg[k] <= '1;
         end
         out_cfg_reg  <= '0;
         upd_en_reg   <= '0;
         add_free_reg <= '0;
      end else if (soft_clr) begin
         for (int k = 0; k < NUM_OUT_PORTS; k++) begin
            dst_leaf_reg[k]  <= '0;
            dst_port_reg[k]  <= NUM_PORT_BITS'(RST_DST_PORT);
            bram_addr_reg[k] <= '0;
            freespace_reg[k] <= '1;
         end
         out_cfg_reg  <= '0;
         upd_en_reg   <= '0;
         add_free_reg <= '0;
      end else begin
         for (int k = 0; k < NUM_OUT_PORTS; k++) begin
            if (out_sel[k]) begin
               dst_leaf_reg[k]  <= fld_leaf;
               dst_port_reg[k]  <= fld_port;
               bram_addr_reg[k] <= fld_addr;
               freespace_reg[k] <= fld_free;
            end
         end
         out_cfg_reg  <= out_cfg_reg | out_sel;
         // Pulses are one-cycle strobes; repeated writes keep them asserted
         upd_en_reg   <= out_sel;
         add_free_reg <= add_sel & {NUM_OUT_PORTS{payload[0]}};
      end
   end

   always_comb begin
      ack_gen    = 1'b0;
      ack_status = ST_OK;
      rb_fields  = '0;
      if (is_cfg_out || is_cfg_in) begin
         ack_gen = 1'b1;
         if (soft_clr)
            ack_status = ST_CLR;
         else if ((is_cfg_out && |out_match) || (is_cfg_in && |in_match))
            ack_status = ST_OK;
         else
            ack_status = ST_BADPORT;
      end
`ifdef CFG_READBACK_EN
      else if (accept && (port_idx == PORT_RDBK) && (|in_match || |out_match)) begin
         ack_gen    = 1'b1;
         ack_status = ST_RDBK;
         for (int k = 0; k < NUM_IN_PORTS; k++) begin
            if (in_match[k])
               rb_fields = {src_leaf_reg[k], src_port_reg[k], {(2*NUM_ADDR_BITS){1'b0}}};
         end
         for (int k = 0; k < NUM_OUT_PORTS; k++) begin
            if (out_match[k])
               rb_fields = {dst_leaf_reg[k], dst_port_reg[k], bram_addr_reg[k], freespace_reg[k]};
         end
      end
`endif
   end

   always_comb begin
      ack_pkt                                      = '0;
      ack_pkt[PACKET_BITS-1]                       = 1'b1;
      ack_pkt[PACKET_BITS-2 -: NUM_LEAF_BITS]      = NUM_LEAF_BITS'(ACK_LEAF);
      ack_pkt[PORT_MSB -: NUM_PORT_BITS]           = NUM_PORT_BITS'(ACK_PORT);
      ack_pkt[PAYLOAD_BITS-1 -: NUM_PORT_BITS+4+RB_W] = {self_port, ack_status, rb_fields};
   end

   config_ack_slot #(
      .PACKET_BITS (PACKET_BITS)
   ) u_ack_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (ack_gen),
      .load_data (ack_pkt),
      .ack_ready (cfg.ack_ready),
      .ack_valid (cfg.ack_valid),
      .ack_out   (cfg.ack_out)
   );

   assign in_configured  = in_cfg_reg;
   assign out_configured = out_cfg_reg;
   assign all_configured = (&in_cfg_reg) && (&out_cfg_reg);

endmodule

// File: tb/tb_config_controls_gen.sv
// Scoreboard bench for config_controls_gen: directed packets, acks checked by a monitor.
module tb_config_controls_gen;

   logic         clk;
   logic         reset_n;
   logic [258:0] control_reg;
   logic [6:0]   in_configured;
   logic [6:0]   out_configured;
   logic         all_configured;

   int n_total;
   int n_pass;

   logic [96:0] exp_q [$];
   logic [9:0]  m_in  [7];
   logic [23:0] m_out [7];

   config_controls_gen_if #(.PACKET_BITS(97)) bus ();

   config_controls_gen dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .cfg            (bus),
      .control_reg    (control_reg),
      .in_configured  (in_configured),
      .out_configured (out_configured),
      .all_configured (all_configured)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [258:0] got, input logic [258:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", name, got, exp);
   endtask

   function automatic logic [96:0] mk(input int port, input int self_p, input int leaf,
                                      input int fport, input int addr, input int free, input int b0);
      return {1'b1, 6'd0, 4'(port), 22'd0, 4'(self_p), 6'(leaf), 4'(fport), 7'(addr), 7'(free), 35'd0, 1'(b0)};
   endfunction

   function automatic logic [96:0] ack(input int self_p, input int status, input logic [23:0] rb);
      return {1'b1, 6'd0, 4'd1, 22'd0, 4'(self_p), 4'(status), rb, 32'd0};
   endfunction

   function automatic logic [258:0] model_ctrl(input logic [6:0] upd, input logic [6:0] addf);
      logic [258:0] v;
      v = '0;
      for (int k = 0; k < 7; k++) begin
         v[10*k +: 10]      = m_in[k];
         v[70+27*k +: 27]   = {upd[k], upd[k], addf[k], m_out[k]};
      end
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 7; k++) begin
         m_in[k]  = {6'd0, 4'd9};
         m_out[k] = {6'd0, 4'd2, 7'd0, 7'd127};
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [96:0] pkt, input bit has_ack, input logic [96:0] exp_ack);
      bit done;
      done = 1'b0;
      bus.configure_in = pkt;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (bus.configure_ready) done = 1'b1;
      end
      if (done) begin
         if (has_ack) exp_q.push_back(exp_ack);
         $display("send port=%0d self=%0d ack=%0d", pkt[89:86], pkt[63:60], has_ack);
      end else begin
         n_total++;
         $display("FAIL send_timeout got=ready_low exp=ready_high");
      end
      tick();
      bus.configure_in = '0;
   endtask

   always @(negedge clk) begin
      if (reset_n && bus.ack_valid && bus.ack_ready) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL ack_unexpected got=%h exp=none", bus.ack_out);
         end else begin
            $display("ack self=%0d status=%0d", bus.ack_out[63:60], bus.ack_out[59:56]);
            check("ack_pkt", 259'(bus.ack_out), 259'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      n_total = 0;
      n_pass  = 0;
      reset_n = 1'b0;
      bus.configure_in = '0;
      bus.ack_ready    = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      check("rst_ctrl", control_reg, model_ctrl(7'h00, 7'h00));
      check("rst_ack_valid", 259'(bus.ack_valid), 259'(0));
      check("rst_ready", 259'(bus.configure_ready), 259'(1));
      check("rst_in_cfg", 259'(in_configured), 259'(0));
      check("rst_out_cfg", 259'(out_configured), 259'(0));

      // Output port 0 configuration with a one-cycle update pulse
      tick();
      bus.ack_ready = 1'b1;
      send(mk(0, 9, 5, 3, 10, 64, 0), 1'b1, ack(9, 1, 24'd0));
      m_out[0] = {6'd5, 4'd3, 7'd10, 7'd64};
      @(negedge clk);
      check("out0_pulse", control_reg, model_ctrl(7'h01, 7'h00));
      @(negedge clk);
      check("out0_settle", control_reg, model_ctrl(7'h00, 7'h00));
      check("out_cfg_first", 259'(out_configured), 259'(7'h01));

      // Backpressure: second packet held while the first ack is not drained
      tick();
      bus.ack_ready = 1'b0;
      send(mk(1, 2, 7, 4, 0, 0, 0), 1'b1, ack(2, 1, 24'd0));
      m_in[0] = {6'd7, 4'd4};
      fork
         send(mk(1, 3, 8, 5, 0, 0, 0), 1'b1, ack(3, 1, 24'd0));
         begin
            repeat (2) @(negedge clk);
            check("held_ready", 259'(bus.configure_ready), 259'(0));
            check("held_in_cfg", 259'(in_configured), 259'(7'h01));
            tick();
            bus.ack_ready = 1'b1;
         end
      join
      m_in[1] = {6'd8, 4'd5};
      @(negedge clk);
      check("in_cfg_two", 259'(in_configured), 259'(7'h03));
      check("in_ctrl", control_reg, model_ctrl(7'h00, 7'h00));

      // Bad self_port, then soft clear
      tick();
      send(mk(1, 15, 33, 6, 0, 0, 0), 1'b1, ack(15, 3, 24'd0));
      @(negedge clk);
      check("badport_nochange", control_reg, model_ctrl(7'h00, 7'h00));
      tick();
      send(mk(0, 0, 0, 0, 0, 0, 0), 1'b1, ack(0, 2, 24'd0));
      model_reset();
      @(negedge clk);
      check("clr_ctrl", control_reg, model_ctrl(7'h00, 7'h00));
      check("clr_in_cfg", 259'(in_configured), 259'(0));
      check("clr_out_cfg", 259'(out_configured), 259'(0));

      // Credit return on packet port 10 -> output port 1
      tick();
      send(mk(10, 0, 0, 0, 0, 0, 1), 1'b0, '0);
      @(negedge clk);
      check("add_free_pulse", control_reg, model_ctrl(7'h00, 7'h02));
      @(negedge clk);
      check("add_free_done", control_reg, model_ctrl(7'h00, 7'h00));
      tick();
      send(mk(10, 0, 0, 0, 0, 0, 0), 1'b0, '0);
      @(negedge clk);
      check("add_free_zero", control_reg, model_ctrl(7'h00, 7'h00));

      // Configure every port back to back
      tick();
      for (int k = 0; k < 7; k++) begin
         send(mk(1, 2 + k, k + 1, k, 0, 0, 0), 1'b1, ack(2 + k, 1, 24'd0));
         m_in[k] = {6'(k + 1), 4'(k)};
      end
      for (int k = 0; k < 7; k++) begin
         send(mk(0, 9 + k, k + 10, k, 3 * k + 1, 100 - k, 0), 1'b1, ack(9 + k, 1, 24'd0));
         m_out[k] = {6'(k + 10), 4'(k), 7'(3 * k + 1), 7'(100 - k)};
      end
      @(negedge clk);
      check("all_last_pulse", control_reg, model_ctrl(7'h40, 7'h00));
      @(negedge clk);
      check("all_ctrl", control_reg, model_ctrl(7'h00, 7'h00));
      check("all_in_cfg", 259'(in_configured), 259'(7'h7f));
      check("all_out_cfg", 259'(out_configured), 259'(7'h7f));
      check("all_configured", 259'(all_configured), 259'(1));

`ifdef CFG_READBACK_EN
      tick();
      send(mk(0, 9, 5, 3, 10, 64, 0), 1'b1, ack(9, 1, 24'd0));
      m_out[0] = {6'd5, 4'd3, 7'd10, 7'd64};
      send(mk(2, 9, 0, 0, 0, 0, 0), 1'b1, ack(9, 4, {6'd5, 4'd3, 7'd10, 7'd64}));
      send(mk(2, 3, 0, 0, 0, 0, 0), 1'b1, ack(3, 4, {6'd2, 4'd1, 14'd0}));
      @(negedge clk);
      check("rdbk_ctrl", control_reg, model_ctrl(7'h00, 7'h00));
`else
      tick();
      send(mk(2, 9, 0, 0, 0, 0, 0), 1'b0, '0);
      @(negedge clk);
      check("rdbk_silent", 259'(bus.ack_valid), 259'(0));
`endif

      // Reset while an ack is pending
      @(negedge clk);
      tick();
      bus.ack_ready = 1'b0;
      send(mk(1, 4, 1, 1, 0, 0, 0), 1'b0, '0);
      @(negedge clk);
      check("pend_before_reset", 259'(bus.ack_valid), 259'(1));
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check("reset_drops_ack", 259'(bus.ack_valid), 259'(0));
      check("reset_ready", 259'(bus.configure_ready), 259'(1));
      check("reset_ctrl", control_reg, model_ctrl(7'h00, 7'h00));
      check("reset_in_cfg", 259'(in_configured), 259'(0));
      @(negedge clk);
      reset_n = 1'b1;

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 259'(exp_q.size()), 259'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
